// File: rtl/spi_pixel_fb_writer.sv
// spi_pixel_fb_writer: converts RGB888 pixel groups to RGB565, buffers them in a
// small FIFO and writes them to a frame buffer at a linear raster address.
// Frame boundaries follow the synchronised SPI chip-select level.
module spi_pixel_fb_writer #(
    parameter int unsigned H_RES     = 320,
    parameter int unsigned V_RES     = 240,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              css,
    input  logic              group_rdy,
    input  logic [23:0]       group_dat,
    input  logic              wr_full,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_dat,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              overflow
);

    localparam int unsigned FRAME_W = ADDR_W + 1;
    localparam int unsigned CNT_W   = FIFO_AW + 1;
    localparam int unsigned DEPTH   = 2 ** FIFO_AW;
    localparam int unsigned X_W     = $clog2(H_RES + 1);
    localparam int unsigned Y_W     = $clog2(V_RES + 1);

    localparam logic [FRAME_W-1:0] FRAME_PIX = FRAME_W'(H_RES * V_RES);
    localparam logic [FRAME_W-1:0] PIX_SAT   = FRAME_PIX + FRAME_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(BASE_ADDR + H_RES * V_RES - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [X_W-1:0]     X_LAST    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0]     Y_LAST    = Y_W'(V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_css_meta, r_css_s, r_css_d;
    logic                 r_rise_pend;
    logic [15:0]          r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr, r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [ADDR_W-1:0]    r_addr_cnt;
    logic [X_W-1:0]       r_x;
    logic [Y_W-1:0]       r_y;
    logic [FRAME_W-1:0]   r_pix_cnt;
    logic                 r_wr_en;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [15:0]          r_wr_dat;
    logic                 r_frame_done, r_frame_ok, r_overflow;

    logic        w_css_rise, w_css_fall;
    logic        w_full, w_empty;
    logic        w_push_req, w_push, w_pop, w_drop, w_start;
    logic [15:0] w_rgb565;
    logic        w_unused_bits;

    assign w_css_rise = r_css_s & ~r_css_d;
    assign w_css_fall = ~r_css_s & r_css_d;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_pop      = ~w_empty & ~wr_full;
    assign w_push_req = (r_state == S_ACTIVE) & group_rdy;
    // A full FIFO still takes the pixel when a pop frees a slot in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push;
    assign w_start    = (r_state == S_IDLE) & (w_css_rise | r_rise_pend);

    assign w_rgb565      = {group_dat[23:19], group_dat[15:10], group_dat[7:3]};
    assign w_unused_bits = &{group_dat[18:16], group_dat[9:8], group_dat[2:0]};

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_dat     = r_wr_dat;
    assign frame_done = r_frame_done;
    assign frame_ok   = r_frame_ok;
    assign overflow   = r_overflow;

    // Two-flop synchroniser for chip select plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: registers always take non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_css_meta <= 1'b0;
            r_css_s    <= 1'b0;
            r_css_d    <= 1'b0;
        end else begin
            r_css_meta <= css;
            r_css_s    <= r_css_meta;
            r_css_d    <= r_css_s;
        end
    end

    // FIFO storage array, written on each accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
        if (w_push) begin
            r_mem[r_wptr] <= w_rgb565;
        end
    end

    // FIFO pointers and occupancy count; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
            if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered frame-buffer write port with a wrapping linear address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_dat   <= '0;
            r_addr_cnt <= ADDR_BASE;
        end else begin
            r_wr_en <= w_pop;
            if (w_pop) begin
                r_wr_addr <= r_addr_cnt;
                r_wr_dat  <= r_mem[r_rptr];
            end
            // The FIFO is always empty in IDLE, so the restart never collides with a pop.
            if (w_start) begin
                r_addr_cnt <= ADDR_BASE;
            end else if (w_pop) begin
                r_addr_cnt <= (r_addr_cnt == ADDR_LAST) ? ADDR_BASE : r_addr_cnt + ADDR_W'(1);
            end
        end
    end

    // Frame FSM with raster counters, overflow tracking and frame completion status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rise_pend  <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_pix_cnt    <= '0;
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;

            if (w_push) begin
                if (r_pix_cnt != PIX_SAT) r_pix_cnt <= r_pix_cnt + FRAME_W'(1);
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
            if (w_drop) r_overflow <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state     <= S_ACTIVE;
                        r_rise_pend <= 1'b0;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_pix_cnt   <= '0;
                        r_overflow  <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (w_css_fall) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // A new frame that starts while draining is remembered for the IDLE entry cycle.
                    if (w_css_rise) r_rise_pend <= 1'b1;
                    if (w_empty) begin
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                        r_frame_ok   <= (r_pix_cnt == FRAME_PIX) && !r_overflow;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_pixel_fb_writer.sv
// Self-checking bench for spi_pixel_fb_writer on a 4x2 frame with a 16-deep FIFO.
// Expected writes come from a pixel-level model: accepted pixel k lands at
// BASE + (k mod H*V) with its RGB565 value computed arithmetically.
module tb_spi_pixel_fb_writer;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int AW    = 17;
    localparam int BASE  = 0;
    localparam int FAW   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = H * V;

    logic          clk = 1'b0;
    logic          rst, css, group_rdy, wr_full;
    logic [23:0]   group_dat;
    logic          wr_en, frame_done, frame_ok, overflow;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_dat;

    spi_pixel_fb_writer #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .BASE_ADDR(BASE), .FIFO_AW(FAW)
    ) dut (
        .clk(clk), .rst(rst), .css(css), .group_rdy(group_rdy), .group_dat(group_dat),
        .wr_full(wr_full), .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
        .frame_done(frame_done), .frame_ok(frame_ok), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];
    int          done_cnt = 0;
    logic        last_ok, last_ovf;
    int          k;

    // Capture observed writes and frame completions away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) obs_q.push_back({wr_addr, wr_dat});
        if (frame_done === 1'b1) begin
            done_cnt++;
            last_ok  = frame_ok;
            last_ovf = overflow;
        end
    end

    function automatic logic [15:0] to565(logic [23:0] p);
        int r, g, b;
        r = int'(p) / 65536;
        g = (int'(p) / 256) % 256;
        b = int'(p) % 256;
        return 16'((r / 8) * 2048 + (g / 4) * 32 + (b / 8));
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(logic [23:0] p, bit accept);
        logic [AW-1:0] a;
        group_dat = p;
        group_rdy = 1'b1;
        step(1);
        group_rdy = 1'b0;
        if (accept) begin
            a = AW'(BASE + (k % FRAME));
            exp_q.push_back({a, to565(p)});
            k++;
        end
    endtask

    task automatic begin_frame();
        css = 1'b1;
        step(5);
        k = 0;
    endtask

    task automatic compare_writes(string tag);
        int n;
        check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(string tag);
        int s, t;
        s = done_cnt;
        t = 0;
        while (done_cnt == s && t < 200) begin
            step(1);
            t++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != s), 64'(1));
    endtask

    task automatic end_frame(string tag, bit ok, bit ovf);
        wr_full = 1'b0;
        css     = 1'b0;
        wait_done(tag);
        check({tag, "_frame_ok"}, 64'(last_ok), 64'(ok));
        check({tag, "_overflow"}, 64'(last_ovf), 64'(ovf));
        step(3);
        compare_writes(tag);
    endtask

    initial begin
        int s;
        bit wf;
        rst = 1'b1; css = 1'b0; group_rdy = 1'b0; wr_full = 1'b0; group_dat = '0;
        k = 0;

        // T1: reset held with group_rdy toggling
        step(1);
        for (int i = 0; i < 3; i++) begin
            group_rdy = ~group_rdy;
            group_dat = 24'($urandom);
            step(1);
            check("t1_wr_en", 64'(wr_en), 64'(0));
            check("t1_frame_done", 64'(frame_done), 64'(0));
            check("t1_overflow", 64'(overflow), 64'(0));
        end
        rst = 1'b0; group_rdy = 1'b0;
        step(3);
        check("t1_no_writes", 64'(obs_q.size()), 64'(0));

        // T2: single pixel latency and conversion
        begin_frame();
        group_dat = 24'hF8FCF8;
        group_rdy = 1'b1;
        step(1);
        group_rdy = 1'b0;
        check("t2_wr_en_n1", 64'(wr_en), 64'(0));
        step(1);
        check("t2_wr_en_n2", 64'(wr_en), 64'(1));
        check("t2_wr_dat", 64'(wr_dat), 64'(16'hFFFF));
        check("t2_wr_addr", 64'(wr_addr), 64'(BASE));
        exp_q.push_back({AW'(BASE), to565(24'hF8FCF8)});
        k = 1;
        end_frame("t2", 1'b0, 1'b0);

        // T3: exact frame with random gaps
        begin_frame();
        for (int i = 0; i < FRAME; i++) begin
            send_pixel(24'($urandom), 1'b1);
            s = int'($urandom_range(0, 2));
            if (s > 0) step(s);
        end
        end_frame("t3", 1'b1, 1'b0);

        // T3b: exact frame under random backpressure
        begin_frame();
        for (int i = 0; i < FRAME; i++) begin
            wf = 1'($urandom_range(0, 1));
            wr_full = wf;
            send_pixel(24'($urandom), 1'b1);
            if (wf) check($sformatf("t3b_block%0d", i), 64'(wr_en), 64'(0));
        end
        end_frame("t3b", 1'b1, 1'b0);

        // T4: overflow with the write port blocked
        begin_frame();
        wr_full = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) send_pixel(24'($urandom), i < DEPTH);
        check("t4_overflow", 64'(overflow), 64'(1));
        step(2);
        check("t4_blocked", 64'(obs_q.size()), 64'(0));
        end_frame("t4", 1'b0, 1'b1);

        // T5: oversized frame wraps the address; next frame restarts clean
        begin_frame();
        check("t5_ovf_clr", 64'(overflow), 64'(0));
        for (int i = 0; i < FRAME + 2; i++) send_pixel(24'($urandom), 1'b1);
        end_frame("t5", 1'b0, 1'b0);
        begin_frame();
        for (int i = 0; i < 3; i++) send_pixel(24'($urandom), 1'b1);
        end_frame("t5b", 1'b0, 1'b0);

        // T6: reset mid-frame with two pixels buffered
        begin_frame();
        send_pixel(24'($urandom), 1'b1);
        step(2);
        wr_full = 1'b1;
        send_pixel(24'($urandom), 1'b0);
        send_pixel(24'($urandom), 1'b0);
        step(1);
        rst = 1'b1; css = 1'b0;
        step(2);
        rst = 1'b0; wr_full = 1'b0;
        check("t6_wr_en_rst", 64'(wr_en), 64'(0));
        s = done_cnt;
        step(20);
        check("t6_no_done", 64'(done_cnt), 64'(s));
        compare_writes("t6");
        begin_frame();
        for (int i = 0; i < 2; i++) send_pixel(24'($urandom), 1'b1);
        end_frame("t6b", 1'b0, 1'b0);

        // T7: new frame requested while the previous one is still draining
        begin_frame();
        wr_full = 1'b1;
        for (int i = 0; i < 4; i++) send_pixel(24'($urandom), 1'b1);
        css = 1'b0;
        step(6);
        css = 1'b1;
        step(6);
        check("t7_held", 64'(obs_q.size()), 64'(0));
        wr_full = 1'b0;
        wait_done("t7a");
        check("t7a_frame_ok", 64'(last_ok), 64'(0));
        check("t7a_overflow", 64'(last_ovf), 64'(0));
        step(2);
        compare_writes("t7a");
        k = 0;
        for (int i = 0; i < FRAME; i++) send_pixel(24'($urandom), 1'b1);
        end_frame("t7b", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
